// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: runs one load or store at a time against the data RAM
// over a req/ack handshake, holds the last loaded byte for write-back, and
// aborts an access that waits too long for its acknowledge.
module mem_access_unit #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              mem_read_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Counter is one bit wider than strictly needed to hold the limit when the
    // limit is zero, so the width never collapses to zero bits.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_timed_out;
    logic                r_illegal_err;

    logic                w_accept;
    logic                w_illegal;
    logic                w_ack;
    logic                w_timeout;
    logic [CNT_W:0]      w_cnt_inc;

    // Start is only honoured in IDLE; exactly one of MemRead/MemWrite must be set.
    assign w_accept  = (r_state == ST_IDLE) && start && (MemRead ^ MemWrite);
    assign w_illegal = (r_state == ST_IDLE) && start && MemRead && MemWrite;
    assign w_ack     = (r_state == ST_ACCESS) && ram_ack;

    // The limit is reached when this wait cycle would bring the count to it;
    // an ack in that same cycle takes priority.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_timeout = TIMEOUT_EN && (r_state == ST_ACCESS) && !ram_ack && (w_cnt_inc == LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        ram_req      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        mem_read_out = 1'b0;
        err          = r_illegal_err;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_req = 1'b1;
                busy    = 1'b1;
                if (w_ack || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                mem_read_out = !r_we;
                err          = r_timed_out;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction latches, wait counter, load result and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_data_out    <= '0;
            r_cnt         <= '0;
            r_timed_out   <= 1'b0;
            r_illegal_err <= 1'b0;
        end else begin
            r_illegal_err <= w_illegal;
            if (w_accept) begin
                r_addr      <= addr;
                r_wdata     <= wdata;
                r_we        <= MemWrite;
                r_cnt       <= '0;
                r_timed_out <= 1'b0;
            end
            // Saturating wait counter: never wraps back to zero.
            if ((r_state == ST_ACCESS) && !ram_ack && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ack && !r_we) begin
                r_data_out <= ram_rdata;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign ram_addr     = r_addr;
    assign ram_wdata    = r_wdata;
    assign ram_we       = r_we;
    assign ram_data_out = r_data_out;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4-cycle access timeout.
module tb_mem_access_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ram_req;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ram_ack;
    logic [7:0] ram_data_out;
    logic       mem_read_out;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .addr(addr),
        .wdata(wdata),
        .ram_req(ram_req),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ack(ram_ack),
        .ram_data_out(ram_data_out),
        .mem_read_out(mem_read_out),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        start = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = d;
        tick();
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = 8'h00; wdata = 8'h00; ram_rdata = 8'h00; ram_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_req", ram_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_dout", ram_data_out, 8'h00);
        check("rst_addr", ram_addr, 8'h00);
        check("rst_wdata", ram_wdata, 8'h00);
        check("rst_we", ram_we, 0);
        check("rst_mro", mem_read_out, 0);

        // T1: load, ack in the first ACCESS cycle
        issue(1'b1, 1'b0, 8'h12, 8'h00);
        check("t1_req", ram_req, 1);
        check("t1_we", ram_we, 0);
        check("t1_addr", ram_addr, 8'h12);
        check("t1_busy", busy, 1);
        check("t1_nodone", done, 0);
        ram_ack = 1'b1; ram_rdata = 8'hA5;
        tick();
        ram_ack = 1'b0; ram_rdata = 8'h00;
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        check("t1_mro", mem_read_out, 1);
        check("t1_req_off", ram_req, 0);
        check("t1_dout", ram_data_out, 8'hA5);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_mro_off", mem_read_out, 0);

        // T2: store with three wait cycles (ack lands on the 4th ACCESS cycle)
        issue(1'b0, 1'b1, 8'h40, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            check("t2_req", ram_req, 1);
            check("t2_we", ram_we, 1);
            check("t2_wdata", ram_wdata, 8'h3C);
            check("t2_addr", ram_addr, 8'h40);
            check("t2_nodone", done, 0);
            tick();
        end
        check("t2_req4", ram_req, 1);
        ram_ack = 1'b1; ram_rdata = 8'hEE;
        tick();
        ram_ack = 1'b0;
        check("t2_done", done, 1);
        check("t2_err", err, 0);
        check("t2_mro", mem_read_out, 0);
        check("t2_dout", ram_data_out, 8'hA5);
        tick();

        // T3: load that times out after 4 ACCESS cycles
        issue(1'b1, 1'b0, 8'h77, 8'h00);
        ram_rdata = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            check("t3_req", ram_req, 1);
            check("t3_nodone", done, 0);
            check("t3_noerr", err, 0);
            tick();
        end
        check("t3_done", done, 1);
        check("t3_err", err, 1);
        check("t3_req_off", ram_req, 0);
        check("t3_dout", ram_data_out, 8'hA5);
        check("t3_mro", mem_read_out, 1);
        tick();
        check("t3_err_pulse", err, 0);
        check("t3_idle", busy, 0);

        // T4: illegal start, then start during ACCESS
        issue(1'b1, 1'b1, 8'h99, 8'h11);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_req", ram_req, 0);
        check("t4_done", done, 0);
        tick();
        check("t4_err_pulse", err, 0);
        check("t4_addr_kept", ram_addr, 8'h77);
        check("t4_busy2", busy, 0);
        issue(1'b1, 1'b0, 8'h20, 8'h00);
        issue(1'b0, 1'b1, 8'h33, 8'h44);
        check("t4_frz_addr", ram_addr, 8'h20);
        check("t4_frz_we", ram_we, 0);
        check("t4_frz_req", ram_req, 1);
        ram_ack = 1'b1; ram_rdata = 8'h5A;
        tick();
        ram_ack = 1'b0;
        check("t4_done2", done, 1);
        check("t4_dout", ram_data_out, 8'h5A);
        tick();
        check("t4_noqueue", busy, 0);
        tick();
        check("t4_noqueue2", busy, 0);

        // ack outside ACCESS is ignored
        ram_ack = 1'b1; ram_rdata = 8'h11;
        tick();
        ram_ack = 1'b0;
        check("stray_ack_dout", ram_data_out, 8'h5A);
        check("stray_ack_done", done, 0);

        // T5: reset while waiting in ACCESS
        issue(1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        check("t5_waiting", ram_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_req", ram_req, 0);
        check("t5_busy", busy, 0);
        check("t5_dout", ram_data_out, 8'h00);
        check("t5_done", done, 0);
        check("t5_addr", ram_addr, 8'h00);
        tick();
        check("t5_done2", done, 0);
        issue(1'b1, 1'b0, 8'h31, 8'h00);
        ram_ack = 1'b1; ram_rdata = 8'hC3;
        tick();
        ram_ack = 1'b0;
        check("t5_after_done", done, 1);
        check("t5_after_dout", ram_data_out, 8'hC3);
        tick();

        // T6: ack on the exact timeout cycle, then back-to-back load
        issue(1'b1, 1'b0, 8'h50, 8'h00);
        tick(); tick(); tick();
        check("t6_req4", ram_req, 1);
        ram_ack = 1'b1; ram_rdata = 8'h6E;
        tick();
        ram_ack = 1'b0;
        check("t6_done", done, 1);
        check("t6_err", err, 0);
        check("t6_dout", ram_data_out, 8'h6E);
        tick();
        check("t6_idle", busy, 0);
        issue(1'b1, 1'b0, 8'h51, 8'h00);
        check("t6_b2b_req", ram_req, 1);
        check("t6_b2b_addr", ram_addr, 8'h51);
        ram_ack = 1'b1; ram_rdata = 8'h7F;
        tick();
        ram_ack = 1'b0;
        check("t6_b2b_done", done, 1);
        check("t6_b2b_dout", ram_data_out, 8'h7F);
        check("t6_b2b_err", err, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
